// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory access unit: decoder store/load codes,
// FSM state type and completion error codes.
package dm_access_pkg;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SW   = 2'b01;
  localparam logic [1:0] MW_SB   = 2'b10;
  localparam logic [1:0] MW_SH   = 2'b11;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/dm_align.sv
// Combinational lane logic: misalignment detection, store byte enables and
// lane replication, and load lane selection with sign/zero extension.
module dm_align
  import dm_access_pkg::*;
(
  input  logic        is_write,
  input  logic [1:0]  mem_write,
  input  logic [2:0]  laddr,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] word,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    lane_wdata = 32'h0;
    if (is_write) begin
      lane_wdata = wdata;
      case (mem_write)
        MW_SB: begin
          be         = 4'b0001 << offset;
          lane_wdata = {4{wdata[7:0]}};
        end
        MW_SH: begin
          misaligned = offset[0];
          be         = offset[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{wdata[15:0]}};
        end
        default: misaligned = (offset != 2'b00);
      endcase
    end else begin
      case (laddr)
        LD_LB, LD_LBU: misaligned = 1'b0;
        LD_LH, LD_LHU: misaligned = offset[0];
        default:       misaligned = (offset != 2'b00);
      endcase
    end
  end

  // Little-endian: lane i holds bits 8i+7:8i.
  assign byte_sel = word[{ld_offset, 3'b000} +: 8];
  assign half_sel = ld_offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = word;
    case (ld_type)
      LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  load_data = {24'h0, byte_sel};
      LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Multi-cycle data-memory access unit: req/ack bus FSM with stall, timeout
// abort, and aligned/extended load return to write-back.
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_valid,
  input  logic        mem_read,
  input  logic [1:0]  mem_write,
  input  logic [2:0]  laddr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic [1:0]  err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output state_t      fsm_state
);

  // Bus handshake: bus_req is high for every REQ cycle and the bus_* payload is
  // held constant until the cycle bus_ack is seen high with bus_req, at which
  // point read data is taken from bus_rdata in that same cycle.

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [2:0]  ld_type;
  logic [1:0]  ld_offset;
  logic        is_write, start, timeout_hit, misaligned;
  logic [3:0]  be;
  logic [31:0] lane_wdata, load_data;

  assign is_write    = (mem_write != MW_NONE);
  assign start       = acc_valid && (mem_read || is_write);
  assign timeout_hit = (cnt == TO_LAST);
  assign fsm_state   = state;

  dm_align u_align (
    .is_write   (is_write),
    .mem_write  (mem_write),
    .laddr      (laddr),
    .offset     (addr[1:0]),
    .wdata      (wdata),
    .ld_type    (ld_type),
    .ld_offset  (ld_offset),
    .word       (bus_rdata),
    .misaligned (misaligned),
    .be         (be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    bus_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stall      = 1'b1;
          state_next = misaligned ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || timeout_hit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 8'h0;
      ld_type   <= LD_LW;
      ld_offset <= 2'b00;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      rdata     <= 32'h0;
      err       <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt       <= 8'h0;
            ld_type   <= laddr;
            ld_offset <= addr[1:0];
            bus_we    <= is_write;
            bus_be    <= be;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= lane_wdata;
            rdata     <= 32'h0;
            err       <= misaligned ? ERR_MISALIGN : ERR_OK;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            rdata <= bus_we ? 32'h0 : load_data;
            err   <= ERR_OK;
          end else begin
            cnt <= cnt + 8'h1;
            if (timeout_hit) begin
              rdata <= 32'h0;
              err   <= ERR_TIMEOUT;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed vector table, hand sequences for the
// timeout/late-ack and mid-transaction reset cases, and randomized accesses.
module tb_dm_access_unit;
  import dm_access_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        acc_valid, mem_read;
  logic [1:0]  mem_write;
  logic [2:0]  laddr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done;
  logic [1:0]  err;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  state_t      fsm_state;

  int errors = 0;
  int checks = 0;

  logic [33:0] exp_q[$];

  typedef struct {
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          req_cycles;
    logic        we;
  } exp_t;

  typedef struct {
    logic [1:0]  mw;
    logic        rd;
    logic [2:0]  ld;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rw;
    int          aw;
    exp_t        e;
  } vec_t;

  dm_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (acc_valid),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .laddr     (laddr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_be    (bus_be),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .fsm_state (fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: access size and lane arithmetic from the rules directly.
  function automatic exp_t model(input logic [1:0] mw, input logic rd, input logic [2:0] ld,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rw, input int aw);
    exp_t e;
    int size, off;
    bit wr, sgn;
    logic [31:0] mask, f;
    wr  = (mw != 2'b00);
    off = int'(a[1:0]);
    if (wr) size = (mw == 2'b10) ? 1 : (mw == 2'b11) ? 2 : 4;
    else    size = (ld == 3'b001 || ld == 3'b010) ? 1 : (ld == 3'b011 || ld == 3'b100) ? 2 : 4;
    sgn = (ld == 3'b001 || ld == 3'b011);
    e.we     = wr;
    e.baddr  = a - 32'(off);
    e.be     = wr ? 4'(((1 << size) - 1) << off) : 4'hF;
    if (size == 1)      e.bwdata = (wd & 32'hFF) * 32'h01010101;
    else if (size == 2) e.bwdata = (wd & 32'hFFFF) * 32'h00010001;
    else                e.bwdata = wd;
    e.rdata = 32'h0;
    if (off % size != 0) begin
      e.err = 2'b01;
      e.req_cycles = 0;
    end else if (aw >= TO) begin
      e.err = 2'b10;
      e.req_cycles = TO;
    end else begin
      e.err = 2'b00;
      e.req_cycles = aw + 1;
      if (!wr) begin
        if (size == 4) e.rdata = rw;
        else begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          f = (rw >> (8 * off)) & mask;
          if (sgn && f > (mask >> 1)) f = f - (32'h1 << (8 * size));
          e.rdata = f;
        end
      end
    end
    return e;
  endfunction

  function automatic vec_t mkv(input logic [1:0] mw, input logic rd, input logic [2:0] ld,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                               input int aw, input logic [3:0] be, input logic [31:0] baddr,
                               input logic [31:0] bwd, input logic [31:0] rdat,
                               input logic [1:0] er, input int req, input logic we);
    vec_t v;
    v.mw = mw; v.rd = rd; v.ld = ld; v.a = a; v.wd = wd; v.rw = rw; v.aw = aw;
    v.e.be = be; v.e.baddr = baddr; v.e.bwdata = bwd; v.e.rdata = rdat;
    v.e.err = er; v.e.req_cycles = req; v.e.we = we;
    return v;
  endfunction

  // driver: one full access from start cycle to the done cycle
  task automatic do_access(input vec_t v, input string tag);
    int req_cycles = 0;
    bit got_done = 0;
    logic [33:0] exp_word;
    @(negedge clk);
    acc_valid = 1'b1; mem_read = v.rd; mem_write = v.mw; laddr = v.ld;
    addr = v.a; wdata = v.wd;
    exp_q.push_back({v.e.err, v.e.rdata});
    #1;
    chk({tag, "_stall_start"}, stall, 1'b1);
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      @(negedge clk);
      acc_valid = 1'b0;
      bus_ack   = 1'b0;
      #1;
      if (done) begin
        got_done = 1;
        exp_word = exp_q.pop_front();
        chk({tag, "_rdata"}, rdata, exp_word[31:0]);
        chk({tag, "_err"}, err, exp_word[33:32]);
        chk({tag, "_stall_done"}, stall, 1'b0);
        chk({tag, "_req_done"}, bus_req, 1'b0);
        chk({tag, "_req_cycles"}, req_cycles, v.e.req_cycles);
      end else begin
        chk({tag, "_stall_busy"}, stall, 1'b1);
        chk({tag, "_bus_req"}, bus_req, 1'b1);
        chk({tag, "_bus_addr"}, bus_addr, v.e.baddr);
        chk({tag, "_bus_be"}, bus_be, v.e.be);
        chk({tag, "_bus_we"}, bus_we, v.e.we);
        if (v.e.we) chk({tag, "_bus_wdata"}, bus_wdata, v.e.bwdata);
        if (req_cycles == v.aw) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rw;
        end
        req_cycles++;
      end
    end
    bus_ack = 1'b0;
    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL %s_done_wait actual=no_done required=done", tag);
      void'(exp_q.pop_front());
    end
  endtask

  vec_t vecs[12];

  initial begin
    rst = 1'b1; acc_valid = 1'b0; mem_read = 1'b0; mem_write = 2'b00; laddr = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_state", fsm_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // no start condition: no stall
    @(negedge clk);
    acc_valid = 1'b1; mem_read = 1'b0; mem_write = 2'b00;
    #1;
    chk("nostart_stall_a", stall, 1'b0);
    @(negedge clk);
    acc_valid = 1'b0; mem_read = 1'b1;
    #1;
    chk("nostart_stall_b", stall, 1'b0);
    mem_read = 1'b0;

    // directed vectors with hand-derived expectations
    vecs[0]  = mkv(2'b10, 0, 3'd0, 32'h1003, 32'h000000A5, 32'h0, 0,
                   4'b1000, 32'h1000, 32'hA5A5A5A5, 32'h0, 2'b00, 1, 1);
    vecs[1]  = mkv(2'b00, 1, 3'd1, 32'h2001, 32'h0, 32'h12348056, 0,
                   4'hF, 32'h2000, 32'h0, 32'hFFFFFF80, 2'b00, 1, 0);
    vecs[2]  = mkv(2'b00, 1, 3'd2, 32'h2001, 32'h0, 32'h12348056, 0,
                   4'hF, 32'h2000, 32'h0, 32'h00000080, 2'b00, 1, 0);
    vecs[3]  = mkv(2'b00, 1, 3'd3, 32'h2002, 32'h0, 32'hF00D0000, 0,
                   4'hF, 32'h2000, 32'h0, 32'hFFFFF00D, 2'b00, 1, 0);
    vecs[4]  = mkv(2'b00, 1, 3'd4, 32'h2002, 32'h0, 32'hF00D0000, 0,
                   4'hF, 32'h2000, 32'h0, 32'h0000F00D, 2'b00, 1, 0);
    vecs[5]  = mkv(2'b00, 1, 3'd0, 32'h3002, 32'h0, 32'h0, 0,
                   4'hF, 32'h3000, 32'h0, 32'h0, 2'b01, 0, 0);
    vecs[6]  = mkv(2'b01, 0, 3'd0, 32'h4000, 32'hDEADBEEF, 32'h0, 10,
                   4'hF, 32'h4000, 32'hDEADBEEF, 32'h0, 2'b10, 4, 1);
    vecs[7]  = mkv(2'b11, 0, 3'd0, 32'h5002, 32'h1234ABCD, 32'h0, 2,
                   4'b1100, 32'h5000, 32'hABCDABCD, 32'h0, 2'b00, 3, 1);
    vecs[8]  = mkv(2'b11, 0, 3'd0, 32'h5001, 32'h1234ABCD, 32'h0, 0,
                   4'h0, 32'h5000, 32'h0, 32'h0, 2'b01, 0, 1);
    vecs[9]  = mkv(2'b00, 1, 3'd0, 32'h6000, 32'h0, 32'h89ABCDEF, 1,
                   4'hF, 32'h6000, 32'h0, 32'h89ABCDEF, 2'b00, 2, 0);
    vecs[10] = mkv(2'b00, 1, 3'd7, 32'h6004, 32'h0, 32'h11223344, 0,
                   4'hF, 32'h6004, 32'h0, 32'h11223344, 2'b00, 1, 0);
    vecs[11] = mkv(2'b10, 1, 3'd1, 32'h7002, 32'h0000005A, 32'hFFFFFFFF, 0,
                   4'b0100, 32'h7000, 32'h5A5A5A5A, 32'h0, 2'b00, 1, 1);
    for (int i = 0; i < 12; i++) do_access(vecs[i], $sformatf("vec%0d", i));

    // timeout followed by a late ack in DONE and IDLE
    do_access(vecs[6], "late");
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("late_done_%0d", k), done, 1'b0);
      chk($sformatf("late_req_%0d", k), bus_req, 1'b0);
      chk($sformatf("late_stall_%0d", k), stall, 1'b0);
      chk($sformatf("late_state_%0d", k), fsm_state, ST_IDLE);
    end
    bus_ack = 1'b0;

    // reset during REQ of an lw, then a clean lw
    @(negedge clk);
    acc_valid = 1'b1; mem_read = 1'b1; mem_write = 2'b00; laddr = 3'd0; addr = 32'h8000;
    @(negedge clk);
    acc_valid = 1'b0; mem_read = 1'b0;
    #1;
    chk("mid_req_before", bus_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", bus_req, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_bus_be", bus_be, 4'h0);
    chk("mid_rst_bus_addr", bus_addr, 32'h0);
    chk("mid_rst_state", fsm_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    do_access(mkv(2'b00, 1, 3'd0, 32'h8000, 32'h0, 32'h0BADBEEF, 0,
                  4'hF, 32'h8000, 32'h0, 32'h0BADBEEF, 2'b00, 1, 0), "post_rst");

    // randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      v.mw = 2'($urandom_range(0, 3));
      v.rd = (v.mw == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1));
      v.ld = 3'($urandom_range(0, 7));
      v.a  = $urandom();
      v.wd = $urandom();
      v.rw = $urandom();
      v.aw = $urandom_range(0, TO + 1);
      v.e  = model(v.mw, v.rd, v.ld, v.a, v.wd, v.rw, v.aw);
      do_access(v, $sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Multi-cycle data-memory access unit for the single-cycle MIPS core. It sits downstream of the control decoder and consumes its store-size code (MemWrite), load-type code (LAddr) and the ALU-computed address. It runs a req/ack transaction on the data-memory bus, stalls the core until the access completes, and returns aligned, sign/zero-extended load data to the write-back mux.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles to wait for bus_ack before aborting (1..255, 8-bit counter).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- acc_valid  in  1  core presents a memory instruction this cycle.
- mem_read  in  1  load (decoder WDSel == 01).
- mem_write  in  2  00 none, 01 sw, 10 sb, 11 sh.
- laddr  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 treated as lw.
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rt).
- rdata  out  32  extended load data, valid while done = 1.
- stall  out  1  freeze PC/register file.
- done  out  1  one-cycle completion pulse.
- err  out  2  00 ok, 01 misaligned, 10 bus timeout; valid while done = 1.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- bus_addr  out  32  word address, addr[31:2] followed by 2'b00.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  completion. Read data is valid in the same cycle.
- bus_rdata  in  32  read word.

## Operation
- Little-endian byte lanes.
- States are IDLE, REQ and DONE.
- IDLE:
  - An access starts when acc_valid & (mem_read | mem_write != 0).
  - Write has priority if mem_read is also set.
  - On start, register the op, laddr, addr[1:0], bus_addr, bus_be and bus_wdata.
  - Aligned access: go to REQ.
  - Misaligned access: set err = 01 and go to DONE. Misaligned means a halfword with addr[0] = 1, or a word with addr[1:0] != 0.
- REQ:
  - bus_req = 1. Bus outputs are held stable until ack.
  - On bus_ack, capture the extended rdata (write: rdata = 0), set err = 00 and go to DONE.
  - The timeout counter increments every REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, drop bus_req, set err = 10, rdata = 0, and go to DONE.
- DONE: done = 1 and stall = 0, so the core commits. Always return to IDLE next cycle. acc_valid in DONE is ignored.
- Store lanes:
  - sb: be = 0001 shifted left by addr[1:0]; byte replicated ×4.
  - sh: be = 0011 when addr[1] = 0, else 1100; half replicated ×2.
  - sw: be = 1111.
- Load extract:
  - Byte = lane addr[1:0]; half = lanes {addr[1],1}:{addr[1],0}.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the full word.
- Reads: bus_we = 0, bus_be = 1111.

## Timing
- stall is combinational and high during:
  - IDLE with a start condition;
  - every REQ cycle.
- stall is low during DONE, and during IDLE with no start.
- Minimum latency, ack in the first REQ cycle: stall for 2 cycles, done in cycle 3.
- Misaligned access: stall 1 cycle, done in cycle 2.
- Timeout: done arrives TIMEOUT_CYCLES + 2 cycles after start.
- bus_ack outside REQ is ignored.
- Reset values (also on reset mid-transaction): state IDLE, bus_req = 0, done = 0, stall = 0 (with acc_valid low), err = 00, rdata = 0, counter = 0, bus_be = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0.
- bus_req drops asynchronously with rst.

## Structure
- Package dm_access_pkg holds:
  - MemWrite encodings (MW_NONE/SW/SB/SH);
  - LAddr encodings (LD_LW/LB/LBU/LH/LHU);
  - state enum;
  - err codes (ERR_OK/MISALIGN/TIMEOUT).
- Combinational sub-module dm_align handles:
  - misalign detect;
  - store be and lane replication;
  - load lane select and extension.
- The top level holds the FSM, the capture registers and the timeout counter.

## Test plan
- sb, addr = 0x1003, wdata = 0x000000A5, ack on first REQ cycle:
  - bus_be = 1000, bus_wdata = 0xA5A5A5A5, bus_addr = 0x1000;
  - stall for 2 cycles, then done with err = 00.
- lb and lbu from addr = 0x2001, bus_rdata = 0x12348056:
  - lb gives rdata = 0xFFFFFF80;
  - lbu gives rdata = 0x00000080.
- lh and lhu from addr = 0x2002, bus_rdata = 0xF00D0000:
  - lh gives 0xFFFFF00D;
  - lhu gives 0x0000F00D.
- lw from addr = 0x3002: no bus_req; stall 1 cycle; done with err = 01 and rdata = 0.
- sw with bus_ack held low, TIMEOUT_CYCLES = 4:
  - bus_req high for 4 cycles, then drops;
  - done with err = 10.
  - A late ack in DONE/IDLE is ignored.
- rst asserted during REQ of an lw: bus_req and stall drop immediately; the next lw completes normally.
